// File: rtl/grant_pkg.sv
//------------------------------------------------------------------------------
// Module   : grant_pkg
// Brief    : Shared constants, FSM encoding and grant legality helper.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package grant_pkg;

    localparam int N  = 8;
    localparam int IW = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Legal: exactly one grant bit set, and that client is actually pending.
    function automatic logic onehot_legal(input logic [N-1:0] grant,
                                          input logic [N-1:0] pend);
        int cnt;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) cnt++;
        end
        return (cnt == 1) && ((grant & pend) != '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/grant_dispatcher_onehot_enc.sv
//------------------------------------------------------------------------------
// Module   : onehot_enc
// Brief    : 8-to-3 one-hot encoder with a flag for exactly-one-bit-set input.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module onehot_enc
    import grant_pkg::*;
(
    input  logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          onehot_ok
);

    int w_cnt;

    always_comb begin
        idx   = '0;
        w_cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                idx   = idx | IW'(i);
                w_cnt = w_cnt + 1;
            end
        end
        onehot_ok = (w_cnt == 1);
    end

endmodule

`default_nettype wire

// File: rtl/grant_dispatcher.sv
//------------------------------------------------------------------------------
// Module   : grant_dispatcher
// Brief    : Latches request pulses, feeds an external arbiter and issues the
//            granted index to a server over valid/ready, pulsing done on accept.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module grant_dispatcher
    import grant_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_pulse,
    output logic [N-1:0]  arb_req,
    input  logic [N-1:0]  arb_grant,
    output logic          out_valid,
    output logic [IW-1:0] out_idx,
    input  logic          out_ready,
    output logic [N-1:0]  done,
    output logic [7:0]    drop_cnt,
    output logic          grant_err
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_pend;
    logic [N-1:0]   r_cur;
    logic [IW-1:0]  r_idx;
    logic [N-1:0]   r_done;
    logic [7:0]     r_drop_cnt;
    logic           r_grant_err;

    logic [IW-1:0]  w_enc_idx;
    logic           w_enc_ok;
    logic           w_legal;
    logic           w_capture;
    logic           w_accept;
    logic           w_err_set;
    logic [N-1:0]   w_clr;
    logic [N-1:0]   w_drop_mask;
    logic [3:0]     w_drop_num;
    logic [8:0]     w_drop_sum;
    logic [7:0]     w_drop_nxt;

    onehot_enc u_enc (
        .onehot    (arb_grant),
        .idx       (w_enc_idx),
        .onehot_ok (w_enc_ok)
    );

    assign w_legal = w_enc_ok & onehot_legal(arb_grant, r_pend);

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pend != '0) begin
                    if (w_legal) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_err_set   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (out_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The bit being cleared at capture may be re-set in the same cycle without
    // counting as a drop; only still-pending or in-flight clients drop.
    always_comb begin
        w_clr       = w_capture ? arb_grant : '0;
        w_drop_mask = req_pulse & ((r_pend & ~w_clr) |
                                   ((r_state == ISSUE) ? r_cur : '0));
        w_drop_num  = '0;
        for (int i = 0; i < N; i++) begin
            w_drop_num = w_drop_num + {3'b000, w_drop_mask[i]};
        end
        w_drop_sum  = {1'b0, r_drop_cnt} + {5'b00000, w_drop_num};
        w_drop_nxt  = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend      <= '0;
            r_cur       <= '0;
            r_idx       <= '0;
            r_done      <= '0;
            r_drop_cnt  <= '0;
            r_grant_err <= 1'b0;
        end else begin
            r_pend     <= (r_pend & ~w_clr) | (req_pulse & ~w_drop_mask);
            r_drop_cnt <= w_drop_nxt;
            r_done     <= w_accept ? r_cur : '0;
            if (w_capture) begin
                r_cur <= arb_grant;
                r_idx <= w_enc_idx;
            end
            if (w_err_set) begin
                r_grant_err <= 1'b1;
            end
        end
    end

    assign arb_req   = r_pend;
    assign out_valid = (r_state == ISSUE);
    assign out_idx   = r_idx;
    assign done      = r_done;
    assign drop_cnt  = r_drop_cnt;
    assign grant_err = r_grant_err;

endmodule

`default_nettype wire

// File: tb/tb_grant_dispatcher.sv
//------------------------------------------------------------------------------
// Module   : tb_grant_dispatcher
// Brief    : Directed bench for grant_dispatcher with a fixed-priority arbiter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_grant_dispatcher;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_pulse;
    logic [7:0] arb_req;
    logic [7:0] arb_grant;
    logic       out_valid;
    logic [2:0] out_idx;
    logic       out_ready;
    logic [7:0] done;
    logic [7:0] drop_cnt;
    logic       grant_err;

    logic       force_en;
    logic [7:0] force_val;

    int errors;
    int checks;

    // Fixed-priority arbiter: lowest set index wins, overridable for faults.
    always_comb begin
        arb_grant = arb_req & (~arb_req + 8'd1);
        if (force_en) arb_grant = force_val;
    end

    grant_dispatcher dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_pulse (req_pulse),
        .arb_req   (arb_req),
        .arb_grant (arb_grant),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .done      (done),
        .drop_cnt  (drop_cnt),
        .grant_err (grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_pulse = '0; out_ready = 1'b0; force_en = 1'b0; force_val = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (arb_req !== 8'h00) begin errors++; $display("FAIL reset_pend: got %h want 00", arb_req); end
        checks++; if (done !== 8'h00) begin errors++; $display("FAIL reset_done: got %h want 00", done); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        checks++; if (grant_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", grant_err); end
        checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", out_idx); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        req_pulse = 8'h20;
        tick();
        req_pulse = 8'h00;
        checks++; if (arb_req !== 8'h20) begin errors++; $display("FAIL single_pend: got %h want 20", arb_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
        checks++; if (out_idx !== 3'd5) begin errors++; $display("FAIL single_idx: got %0d want 5", out_idx); end
        checks++; if (arb_req !== 8'h00) begin errors++; $display("FAIL single_clr: got %h want 00", arb_req); end
        tick();
        checks++; if (done !== 8'h20) begin errors++; $display("FAIL single_done: got %h want 20", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", out_valid); end
        tick();
        checks++; if (done !== 8'h00) begin errors++; $display("FAIL single_done_pulse: got %h want 00", done); end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b1;
        req_pulse = 8'h06;
        tick();
        req_pulse = 8'h00;
        tick();
        checks++; if (out_idx !== 3'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL simul_first: got v=%b idx=%0d want v=1 idx=1", out_valid, out_idx); end
        checks++; if (arb_req !== 8'h04) begin errors++; $display("FAIL simul_pend: got %h want 04", arb_req); end
        tick();
        checks++; if (done !== 8'h02) begin errors++; $display("FAIL simul_done1: got %h want 02", done); end
        tick();
        checks++; if (out_idx !== 3'd2 || out_valid !== 1'b1 || done !== 8'h00) begin errors++; $display("FAIL simul_second: got v=%b idx=%0d done=%h want v=1 idx=2 done=00", out_valid, out_idx, done); end
        tick();
        checks++; if (done !== 8'h04) begin errors++; $display("FAIL simul_done2: got %h want 04", done); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        req_pulse = 8'h81;
        tick();
        req_pulse = 8'h00;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_idx !== 3'd0) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b idx=%0d want v=1 idx=0", i, out_valid, out_idx); end
            tick();
        end
        req_pulse = 8'h81;
        tick();
        req_pulse = 8'h00;
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL bp_drop: got %0d want 2", drop_cnt); end
        checks++; if (arb_req !== 8'h80) begin errors++; $display("FAIL bp_pend: got %h want 80", arb_req); end
        out_ready = 1'b1;
        tick();
        checks++; if (done !== 8'h01) begin errors++; $display("FAIL bp_done0: got %h want 01", done); end
        tick();
        checks++; if (out_idx !== 3'd7 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_second: got v=%b idx=%0d want v=1 idx=7", out_valid, out_idx); end
        tick();
        checks++; if (done !== 8'h80) begin errors++; $display("FAIL bp_done7: got %h want 80", done); end
        tick();
    endtask

    task automatic test_set_clear();
        out_ready = 1'b0;
        req_pulse = 8'h04;
        tick();
        tick();
        req_pulse = 8'h00;
        checks++; if (arb_req !== 8'h04) begin errors++; $display("FAIL sc_pend: got %h want 04", arb_req); end
        checks++; if (out_idx !== 3'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL sc_capture: got v=%b idx=%0d want v=1 idx=2", out_valid, out_idx); end
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL sc_drop: got %0d want 2", drop_cnt); end
        out_ready = 1'b1;
        tick();
        checks++; if (done !== 8'h04) begin errors++; $display("FAIL sc_done1: got %h want 04", done); end
        tick();
        checks++; if (out_idx !== 3'd2 || out_valid !== 1'b1 || arb_req !== 8'h00) begin errors++; $display("FAIL sc_again: got v=%b idx=%0d pend=%h want v=1 idx=2 pend=00", out_valid, out_idx, arb_req); end
        tick();
        checks++; if (done !== 8'h04) begin errors++; $display("FAIL sc_done2: got %h want 04", done); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        req_pulse = 8'h08;
        tick();
        req_pulse = 8'h10;
        tick();
        req_pulse = 8'h00;
        checks++; if (out_idx !== 3'd3 || out_valid !== 1'b1 || arb_req !== 8'h10) begin errors++; $display("FAIL rm_setup: got v=%b idx=%0d pend=%h want v=1 idx=3 pend=10", out_valid, out_idx, arb_req); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || done !== 8'h00) begin errors++; $display("FAIL rm_async: got v=%b done=%h want v=0 done=00", out_valid, done); end
        checks++; if (arb_req !== 8'h00 || drop_cnt !== 8'd0 || out_idx !== 3'd0) begin errors++; $display("FAIL rm_state: got pend=%h drop=%0d idx=%0d want 00/0/0", arb_req, drop_cnt, out_idx); end
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (done !== 8'h00 || out_valid !== 1'b0) begin errors++; $display("FAIL rm_no_done[%0d]: got done=%h v=%b want 00/0", i, done, out_valid); end
        end
    endtask

    task automatic test_fault();
        out_ready = 1'b0;
        force_en  = 1'b1;
        force_val = 8'h18;
        req_pulse = 8'h18;
        tick();
        req_pulse = 8'h00;
        checks++; if (grant_err !== 1'b0 || arb_req !== 8'h18) begin errors++; $display("FAIL fault_pre: got err=%b pend=%h want 0/18", grant_err, arb_req); end
        tick();
        checks++; if (grant_err !== 1'b1) begin errors++; $display("FAIL fault_err: got %b want 1", grant_err); end
        checks++; if (out_valid !== 1'b0 || arb_req !== 8'h18) begin errors++; $display("FAIL fault_hold: got v=%b pend=%h want 0/18", out_valid, arb_req); end
        force_en = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_idx !== 3'd3 || arb_req !== 8'h10) begin errors++; $display("FAIL fault_recover: got v=%b idx=%0d pend=%h want 1/3/10", out_valid, out_idx, arb_req); end
        checks++; if (grant_err !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %b want 1", grant_err); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_set_clear();
        test_reset_mid();
        test_fault();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
